turn_action_ctrl: RTL

//  Per-turn action sequencer between game_fsm and the projectile/physics engine.

---
 rtl/turn_action_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/turn_action_ctrl.sv
// Per-turn action sequencer: charges throw power, launches, waits for landing,
// applies damage to the opponent and hands the turn back to game_fsm.
module turn_action_ctrl #(
  parameter int unsigned HP_MAX        = 100,
  parameter int unsigned DAMAGE        = 20,
  parameter int unsigned POWER_MAX     = 100,
  parameter int unsigned TIMEOUT_TICKS = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic       dog_turn,
  input  logic       cat_turn,
  input  logic       fire_held_local,
  input  logic       fire_held_remote,
  input  logic       tick,
  input  logic       proj_landed,
  input  logic       proj_hit,
  output logic [6:0] power,
  output logic       launch,
  output logic [6:0] launch_power,
  output logic [9:0] time_left,
  output logic       turn_done_dog,
  output logic       turn_done_cat,
  output logic [9:0] hp_local,
  output logic [9:0] hp_remote
);

  localparam logic [9:0] HP_INIT = 10'(HP_MAX);
  localparam logic [9:0] DMG     = 10'(DAMAGE);
  localparam logic [6:0] PMAX    = 7'(POWER_MAX);
  localparam logic [9:0] TMO     = 10'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {
    IDLE, ARM, AIM, CHARGE, FLIGHT, RESOLVE, DONE, HANDOFF
  } state_t;

  state_t     state, state_next;
  logic       owner;        // 0 = dog (local), 1 = cat (remote)
  logic       dir_down;
  logic       start_q;
  logic [9:0] tick_cnt;

  logic fire, owner_turn, abort, counting, timeout;
  logic do_launch, do_hit, start_edge;

  always_comb begin
    fire       = owner ? fire_held_remote : fire_held_local;
    owner_turn = owner ? cat_turn : dog_turn;
    abort      = (state != IDLE) && (state != HANDOFF) && !owner_turn;
    counting   = (state == ARM) || (state == AIM) || (state == CHARGE);
    timeout    = counting && tick && (tick_cnt == TMO - 10'd1);
    start_edge = start_game && !start_q;

    state_next = state;
    case (state)
      IDLE:    if (dog_turn || cat_turn) state_next = ARM;
      ARM:     if (!fire) state_next = AIM;
      AIM:     if (fire) state_next = CHARGE;
      CHARGE:  if (!fire) state_next = FLIGHT;
      FLIGHT:  if (proj_landed) state_next = proj_hit ? RESOLVE : DONE;
      RESOLVE: state_next = DONE;
      DONE:    state_next = HANDOFF;
      HANDOFF: if (!owner_turn) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort outranks timeout, which outranks a same-cycle release.
    if (timeout) state_next = DONE;
    if (abort)   state_next = IDLE;

    do_launch = (state == CHARGE) && (state_next == FLIGHT);
    do_hit    = (state == RESOLVE) && !abort;

    turn_done_dog = (state == DONE) && !abort && !owner;
    turn_done_cat = (state == DONE) && !abort && owner;
    time_left     = TMO - tick_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      dir_down     <= 1'b0;
      start_q      <= 1'b0;
      tick_cnt     <= '0;
      power        <= '0;
      launch       <= 1'b0;
      launch_power <= '0;
      hp_local     <= HP_INIT;
      hp_remote    <= HP_INIT;
    end else begin
      state   <= state_next;
      start_q <= start_game;
      launch  <= do_launch;

      if (state == IDLE && state_next == ARM) begin
        owner    <= !dog_turn;
        tick_cnt <= '0;
      end else if (counting && tick) begin
        tick_cnt <= tick_cnt + 10'd1;
      end

      if (abort || state == DONE || (state == IDLE && state_next == ARM)) begin
        power    <= '0;
        dir_down <= 1'b0;
      end else if (state == CHARGE && fire && tick) begin
        // Ping-pong between 0 and PMAX, turning around at each end.
        if (!dir_down) begin
          if (power == PMAX) begin
            power    <= power - 7'd1;
            dir_down <= 1'b1;
          end else begin
            power <= power + 7'd1;
          end
        end else begin
          if (power == '0) begin
            power    <= power + 7'd1;
            dir_down <= 1'b0;
          end else begin
            power <= power - 7'd1;
          end
        end
      end

      if (do_launch) launch_power <= power;

      if (start_edge) begin
        hp_local  <= HP_INIT;
        hp_remote <= HP_INIT;
      end else if (do_hit) begin
        if (owner) hp_local  <= (hp_local  <= DMG) ? '0 : hp_local  - DMG;
        else       hp_remote <= (hp_remote <= DMG) ? '0 : hp_remote - DMG;
      end
    end
  end

endmodule
